spi_sensor_target: RTL
======================

SPI_SENSOR_TARGET -- requirements
Module: spi_sensor_target

Interface
REQ-001 Parameter FRAME_BITS, default 16: bits per SPI frame, range 8..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on cs_n and sck, range 2..3.
REQ-003 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port cs_n, input, 1: SPI chip select from initiator, active low, asynchronous to clk.
REQ-006 Port sck, input, 1: SPI clock from initiator, idle low, asynchronous to clk.
REQ-007 Port so, output, 1: serial data to initiator, MSB first.
REQ-008 Port so_oe, output, 1: output enable for so; high only while a frame is selected.
REQ-009 Port load_data, input, FRAME_BITS: next sample word from the sample source.
REQ-010 Port load_valid, input, 1: load_data is valid.
REQ-011 Port load_ready, output, 1: holding register empty; transfer on load_valid & load_ready.
REQ-012 Port frame_done, output, 1: one-clk pulse when cs_n deasserts after a frame.
REQ-013 Port stale, output, 1: last frame started with an empty holding register.
REQ-014 Port short_cnt, output, 8: count of frames aborted before FRAME_BITS falling edges.

Function
REQ-015 cs_n and sck each pass through SYNC_STAGES flops, then one history flop for edge detection.
REQ-016 Operating constraint: clk frequency >= 8x sck frequency; the bench respects it; below it, behaviour is undefined.
REQ-017 States: IDLE, SHIFT, TAIL.
REQ-018 IDLE -> SHIFT on a synchronized cs_n falling edge.
- Same cycle: the holding word copies into the shift register if present, else the previous shift word is reused and stale is set.
- so = MSB, so_oe = 1 from the next cycle.
REQ-019 In SHIFT, each synchronized sck falling edge shifts left by one; so presents the next bit by 1 clk after edge detection.
- Total latency from the sck pin edge is SYNC_STAGES+1 clk.
REQ-020 sck rising edges do not change state; the initiator samples on rising edges.
REQ-021 SHIFT -> TAIL on the falling edge that completes FRAME_BITS shifts (6-bit bit counter, reset to 0 on frame start); so = 0 in TAIL.
REQ-022 SHIFT or TAIL -> IDLE on a synchronized cs_n rising edge, with that cycle's effects:
- frame_done pulses;
- so_oe = 0;
- if exiting from SHIFT, short_cnt increments, saturating at 255.
REQ-023 cs_n rising and sck falling edges detected in the same cycle: cs_n wins; no shift occurs.
REQ-024 load_ready = 1 while the holding register is empty.
- A transfer fills it.
- A frame start empties it. When a frame start and a transfer coincide, the shift register takes the old holding word and the holding register takes the new word.
REQ-025 When the holding register is empty at frame start, a transfer in that same cycle is not used for the frame; stale = 1.
REQ-026 stale updates only at frame start: it is 1 if the holding register was empty, else 0.
REQ-027 In IDLE: so = 0, so_oe = 0, and sck edges are ignored.

Reset
REQ-028 On reset, the following values are set:
- state IDLE;
- shift register 0, holding register empty, bit counter 0;
- synchronizer and history flops all 1 for cs_n and all 0 for sck;
- so = 0, so_oe = 0, load_ready = 1, frame_done = 0, stale = 0, short_cnt = 0.
REQ-029 Reset during SHIFT or TAIL aborts the frame with no frame_done pulse and no short_cnt increment.
- A cs_n already low at reset release does not start a frame; only a later falling edge does.

Structure
REQ-030 A shared package spi_target_pkg holds:
- the state enum type;
- the FRAME_BITS and SYNC_STAGES default constants;
- the short_cnt width constant (8).
REQ-031 A single sub-module, spi_edge_sync, holds one synchronizer plus edge detect, with outputs level, rise and fall.
- It is instantiated once for cs_n and once for sck.
- Its reset value is a parameter.

Verification
REQ-032 Load 16'hA5C3, then run a 16-bit frame at clk/10 -> initiator samples 16'hA5C3, frame_done pulses once, stale = 0.
REQ-033 Run two frames after a single load of 16'h1234 -> the second frame returns 16'h1234 with stale = 1.
REQ-034 Run 20 sck cycles in one frame with 16'hFFFF loaded -> 16 ones then 4 zeros; short_cnt unchanged.
REQ-035 Raise cs_n after 5 bits -> short_cnt = 1, frame_done pulses, so_oe = 0 within SYNC_STAGES+2 clk.
REQ-036 Apply load_valid with 16'h0F0F on the exact frame-start cycle while holding 16'h00FF -> the frame returns 16'h00FF and the next frame returns 16'h0F0F.
REQ-037 Assert reset at bit 7 of a frame, keep cs_n low, release reset -> so_oe stays 0 and short_cnt = 0; the next falling edge on cs_n starts a normal frame.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI sensor target.
// Contents: FSM state type, default frame/synchronizer sizes, short-frame
// counter width and its saturating increment helper.
`timescale 1ns/1ps
package spi_target_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_TAIL  = 2'd2
   } state_e;

   localparam int FRAME_BITS_DEF  = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int SHORT_CNT_W     = 8;

   function automatic logic [SHORT_CNT_W-1:0] sat_inc(input logic [SHORT_CNT_W-1:0] v);
      return (&v) ? v : v + SHORT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer chain plus one history flop for edge detection of an
// asynchronous input.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   din        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : single-cycle strobes on a synchronized edge
`timescale 1ns/1ps
module spi_edge_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
         hist <= RESET_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         hist <= sync[SYNC_STAGES-1];
      end
   end

   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;

endmodule

// File: rtl/spi_sensor_target.sv
// SPI target that streams one sample word per frame, MSB first, shifting
// on sck falling edges so the initiator can sample on rising edges.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   cs_n, sck              : SPI select / clock from the initiator (async)
//   so, so_oe              : serial data out and its output enable
//   load_data/valid/ready  : one-word holding register fill handshake
//   frame_done             : one-clk pulse when a selected frame ends
//   stale                  : last frame started with an empty holding register
//   short_cnt              : saturating count of frames aborted early
`timescale 1ns/1ps
module spi_sensor_target
   import spi_target_pkg::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cs_n,
   input  logic                   sck,
   output logic                   so,
   output logic                   so_oe,
   input  logic [FRAME_BITS-1:0]  load_data,
   input  logic                   load_valid,
   output logic                   load_ready,
   output logic                   frame_done,
   output logic                   stale,
   output logic [SHORT_CNT_W-1:0] short_cnt
);

   logic cs_level, cs_rise, cs_fall;
   logic sck_level, sck_rise, sck_fall;
   logic unused_sck;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .reset(reset), .din(cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk(clk), .reset(reset), .din(sck),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );

   // Rising sck edges are the initiator's sampling point and carry no action here.
   assign unused_sck = sck_level ^ sck_rise;

   state_e                  state;
   logic [FRAME_BITS-1:0]   shreg;
   logic [FRAME_BITS-1:0]   hold;
   logic [FRAME_BITS-1:0]   last_word;
   logic                    hold_full;
   logic [5:0]              bit_cnt;
   logic [1:0]              warm;
   logic                    armed;
   logic                    frame_start, frame_end, xfer;

   // The cs_n synchronizer resets to 1, so a pin already low at reset release
   // would look like a falling edge once the chain flushes. Frames are only
   // accepted after the chain has carried real pin data and shown cs_n high.
   assign frame_start = (state == ST_IDLE) && cs_fall && armed;
   assign frame_end   = (state != ST_IDLE) && cs_rise;
   assign xfer        = load_valid && !hold_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         hold       <= '0;
         last_word  <= '0;
         hold_full  <= 1'b0;
         bit_cnt    <= '0;
         warm       <= '0;
         armed      <= 1'b0;
         stale      <= 1'b0;
         short_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;

         if (warm != 2'(SYNC_STAGES)) warm <= warm + 2'd1;
         else if (cs_level)           armed <= 1'b1;

         // A fill in the frame-start cycle can only happen with the register
         // empty; the new word stays for the next frame.
         if (xfer) begin
            hold      <= load_data;
            hold_full <= 1'b1;
         end else if (frame_start) begin
            hold_full <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  stale   <= !hold_full;
                  if (hold_full) begin
                     shreg     <= hold;
                     last_word <= hold;
                  end else begin
                     shreg <= last_word;
                  end
               end
            end
            ST_SHIFT: begin
               // cs_n release takes priority over a simultaneous sck fall.
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  short_cnt <= sat_inc(short_cnt);
               end else if (sck_fall) begin
                  shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'(FRAME_BITS-1)) state <= ST_TAIL;
               end
            end
            ST_TAIL: begin
               if (cs_rise) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign so         = (state == ST_SHIFT) ? shreg[FRAME_BITS-1] : 1'b0;
   assign so_oe      = (state != ST_IDLE);
   assign load_ready = !hold_full;

endmodule
